// File: rtl/fifo_stream_reader_if.sv
// Valid/ready word stream with burst framing.
// The producer drives valid/data/last and the consumer drives ready.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 16
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port into a registered valid/ready stream with burst framing.
// A small in-order skid buffer absorbs the FIFO read latency so the stream can run at one word per cycle.
module fifo_stream_reader #(
  parameter int WIDTH     = 16,
  parameter int RD_LAT    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_re,
  fifo_stream_reader_if.master out
);

  localparam int NENT = RD_LAT + 2;
  localparam int PW   = $clog2(NENT);
  localparam int OW   = $clog2(NENT + 1);
  localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PW-1:0] LAST_IDX  = PW'(NENT - 1);
  localparam logic [OW:0]   NENT_W    = (OW + 1)'(NENT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [WIDTH-1:0] buf_q [NENT];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OW-1:0]    occ;
  logic             inf;
  logic [BW-1:0]    beat_cnt;

  logic             valid;
  logic             arrive;
  logic             push;
  logic             pop;
  logic [OW:0]      pending;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Words already stored plus the one still in flight must fit, so a read is
  // only issued when a slot is guaranteed; out_ready is deliberately not used.
  always_comb begin
    pending = {1'b0, occ} + {{OW{1'b0}}, inf};
  end

  assign fifo_re = rst && !clear && !fifo_empty && (pending < NENT_W);

  assign arrive = (RD_LAT == 0) ? fifo_re : inf;
  // A word returning during clear belongs to the flushed stream.
  assign push   = arrive && !clear;
  assign valid  = (occ != '0);
  assign pop    = valid && out.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inf      <= 1'b0;
      beat_cnt <= '0;
      for (int i = 0; i < NENT; i++) begin
        buf_q[i] <= '0;
      end
    end else if (clear) begin
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inf      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= fifo_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
      occ <= occ + OW'(push) - OW'(pop);
      inf <= (RD_LAT == 1) ? fifo_re : 1'b0;
    end
  end

  assign out.valid = valid;
  assign out.data  = buf_q[rd_ptr];
  assign out.last  = valid && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one instance at read latency 1 and one at latency 0,
// each fed by a simple FIFO model, with BURST_LEN 4 framing.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  // Latency-1 FIFO model and DUT
  logic [15:0] mem1 [0:255];
  int          rp1 = 0;
  int          wc1 = 0;
  logic        emp1;
  logic [15:0] fd1 = '0;
  logic        re1;

  assign emp1 = (rp1 == wc1);
  always @(posedge clk) begin
    if (re1) begin
      fd1 <= mem1[rp1];
      rp1 <= rp1 + 1;
    end
  end

  fifo_stream_reader_if #(.WIDTH(16)) s1 ();

  fifo_stream_reader #(.WIDTH(16), .RD_LAT(1), .BURST_LEN(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fifo_empty (emp1),
    .fifo_data  (fd1),
    .fifo_re    (re1),
    .out        (s1)
  );

  // Latency-0 FIFO model and DUT
  logic [15:0] mem0 [0:255];
  int          rp0 = 0;
  int          wc0 = 0;
  logic        emp0;
  logic [15:0] fd0;
  logic        re0;

  assign emp0 = (rp0 == wc0);
  assign fd0  = mem0[rp0];
  always @(posedge clk) begin
    if (re0) rp0 <= rp0 + 1;
  end

  fifo_stream_reader_if #(.WIDTH(16)) s0 ();

  fifo_stream_reader #(.WIDTH(16), .RD_LAT(0), .BURST_LEN(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fifo_empty (emp0),
    .fifo_data  (fd0),
    .fifo_re    (re0),
    .out        (s0)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [15:0] first, input int n);
    for (int k = 0; k < n; k++) mem1[wc1 + k] = first + 16'(k);
    wc1 = wc1 + n;
  endtask

  task automatic load0(input logic [15:0] first, input int n);
    for (int k = 0; k < n; k++) mem0[wc0 + k] = first + 16'(k);
    wc0 = wc0 + n;
  endtask

  // Waits (bounded) for a valid word on the latency-1 stream, checks it, and lets it be accepted.
  task automatic expect1(input string tag, input logic [15:0] d, input logic l);
    for (int i = 0; i < 16 && s1.valid !== 1'b1; i++) tick();
    check({tag, "_valid"}, s1.valid, 1'b1);
    check({tag, "_data"}, s1.data, d);
    check({tag, "_last"}, s1.last, l);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    clear      = 1'b0;
    s1.ready   = 1'b1;
    s0.ready   = 1'b1;

    // Reset state with data waiting and consumer ready
    load1(16'h0001, 8);
    #2;
    check("rst_re",    re1, 1'b0);
    check("rst_valid", s1.valid, 1'b0);
    check("rst_data",  s1.data, 16'h0000);
    check("rst_last",  s1.last, 1'b0);
    tick();
    check("rst_hold_valid", s1.valid, 1'b0);
    rst = 1'b1;
    #1;
    check("rel_re_c0", re1, 1'b1);
    tick();
    check("rel_valid_c1", s1.valid, 1'b0);
    check("rel_data_c1",  s1.data, 16'h0000);
    check("rel_last_c1",  s1.last, 1'b0);
    check("rel_re_c1",    re1, 1'b1);
    tick();

    // Stream at RD_LAT=1: one word per cycle from 2 cycles after the first read
    for (int k = 1; k <= 8; k++) begin
      check("str1_valid", s1.valid, 1'b1);
      check("str1_data",  s1.data, 16'(k));
      check("str1_last",  s1.last, (k == 4 || k == 8));
      tick();
    end
    check("str1_end_valid", s1.valid, 1'b0);
    check("str1_end_re",    re1, 1'b0);

    // Backpressure at RD_LAT=1
    s1.ready = 1'b0;
    load1(16'h0001, 8);
    #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (re1) cnt++;
      tick();
    end
    check("bp1_re_pulses", cnt, 3);
    check("bp1_valid", s1.valid, 1'b1);
    check("bp1_hold",  s1.data, 16'h0001);
    check("bp1_last",  s1.last, 1'b0);
    s1.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("bp1_valid", s1.valid, 1'b1);
      check("bp1_data",  s1.data, 16'(k));
      check("bp1_last",  s1.last, (k == 4 || k == 8));
      tick();
    end
    check("bp1_end_valid", s1.valid, 1'b0);

    // Empty gap inside a burst does not restart the beat count
    load1(16'h0011, 2);
    expect1("gap_w1", 16'h0011, 1'b0);
    expect1("gap_w2", 16'h0012, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("gap_valid_low", s1.valid, 1'b0);
      tick();
    end
    load1(16'h0013, 2);
    expect1("gap_w3", 16'h0013, 1'b0);
    expect1("gap_w4", 16'h0014, 1'b1);

    // Clear with a word in flight; beat count is at 3 beforehand
    load1(16'h001d, 3);
    expect1("clr_pre1", 16'h001d, 1'b0);
    expect1("clr_pre2", 16'h001e, 1'b0);
    expect1("clr_pre3", 16'h001f, 1'b0);
    tick();
    check("clr_idle_valid", s1.valid, 1'b0);
    s1.ready = 1'b0;
    load1(16'h0021, 4);
    tick();
    tick();
    tick();
    check("clr_pre_valid", s1.valid, 1'b1);
    check("clr_pre_data",  s1.data, 16'h0021);
    check("clr_pre_re",    re1, 1'b0);
    clear = 1'b1;
    #1;
    check("clr_cycle_re", re1, 1'b0);
    tick();
    clear = 1'b0;
    check("clr_post_valid", s1.valid, 1'b0);
    check("clr_post_last",  s1.last, 1'b0);
    #1;
    check("clr_post_re", re1, 1'b1);
    s1.ready = 1'b1;
    expect1("clr_next", 16'h0024, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("clr_no_stale", s1.valid, 1'b0);
      tick();
    end

    // Asynchronous reset in the middle of a burst
    load1(16'h0031, 8);
    expect1("mrst_w1", 16'h0031, 1'b0);
    expect1("mrst_w2", 16'h0032, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_valid", s1.valid, 1'b0);
    check("mrst_data",  s1.data, 16'h0000);
    check("mrst_last",  s1.last, 1'b0);
    check("mrst_re",    re1, 1'b0);
    wc1 = rp1;
    tick();
    load1(16'h0041, 4);
    rst = 1'b1;
    expect1("mrst_b0", 16'h0041, 1'b0);
    expect1("mrst_b1", 16'h0042, 1'b0);
    expect1("mrst_b2", 16'h0043, 1'b0);
    expect1("mrst_b3", 16'h0044, 1'b1);

    // RD_LAT=0 stream: full throughput
    s0.ready = 1'b1;
    load0(16'h0001, 8);
    #1;
    check("str0_re_c0",    re0, 1'b1);
    check("str0_valid_c0", s0.valid, 1'b0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      check("str0_valid", s0.valid, 1'b1);
      check("str0_data",  s0.data, 16'(k));
      check("str0_last",  s0.last, (k == 4 || k == 8));
      tick();
    end
    check("str0_end_valid", s0.valid, 1'b0);

    // RD_LAT=0 backpressure
    s0.ready = 1'b0;
    load0(16'h0001, 8);
    #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (re0) cnt++;
      tick();
    end
    check("bp0_re_pulses", cnt, 2);
    check("bp0_valid", s0.valid, 1'b1);
    check("bp0_hold",  s0.data, 16'h0001);
    s0.ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("bp0_valid", s0.valid, 1'b1);
      check("bp0_data",  s0.data, 16'(k));
      check("bp0_last",  s0.last, (k == 4 || k == 8));
      tick();
    end
    check("bp0_end_valid", s0.valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
